// File: rtl/cpu_trace_capture_if.sv
// Trace record stream: one retired-instruction record per beat, valid/ready handshake.
// The producer holds the record stable while valid is high and ready is low.
interface cpu_trace_capture_if;
    logic        tr_valid;
    logic        tr_ready;
    logic [31:0] tr_pc;
    logic [5:0]  tr_op;
    logic [4:0]  tr_waddr;
    logic [31:0] tr_wdata;

    modport master (output tr_valid, tr_pc, tr_op, tr_waddr, tr_wdata, input tr_ready);
    modport slave  (input tr_valid, tr_pc, tr_op, tr_waddr, tr_wdata, output tr_ready);
endinterface

// File: rtl/cpu_trace_capture.sv
// Arm/trigger instruction trace: captures a CAPTURE_LEN window of CPU records into a FIFO.
// One-cycle sample-to-stream latency; a full FIFO drops new records (counted) unless popped that cycle.
module cpu_trace_capture #(
    parameter int DEPTH       = 16,
    parameter int CAPTURE_LEN = 64,
    parameter int FILTER_WB   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic [31:0]              trig_addr,
    input  logic [31:0]              currentAddress,
    input  logic [5:0]               op,
    input  logic [4:0]               write_addr,
    input  logic [31:0]              WD,
    input  logic                     reg_write,
    cpu_trace_capture_if.master      tr,
    output logic [1:0]               state,
    output logic [7:0]               count,
    output logic [7:0]               dropped,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;
    localparam logic [7:0]  LEN      = 8'(CAPTURE_LEN);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          new_rec;
    rec_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          hit;
    logic          eligible;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic          last;

    always_comb begin
        hit      = (currentAddress == trig_addr);
        eligible = ((state == S_CAPTURE) || ((state == S_ARMED) && hit)) &&
                   ((FILTER_WB == 0) || reg_write);
        full     = (level == FULL_LVL);
        pop      = tr.tr_valid && tr.tr_ready;
        // A pop in the same cycle frees the slot the new record needs.
        push     = eligible && (!full || pop);
        drop     = eligible && !push;
        last     = eligible && ((count + 8'd1) == LEN);
        new_rec  = '{pc: currentAddress, op: op,
                     waddr: reg_write ? write_addr : 5'd0,
                     wdata: reg_write ? WD : 32'd0};
        head     = mem[rd_ptr];
    end

    assign tr.tr_valid = (level != '0);
    assign tr.tr_pc    = tr.tr_valid ? head.pc    : 32'd0;
    assign tr.tr_op    = tr.tr_valid ? head.op    : 6'd0;
    assign tr.tr_waddr = tr.tr_valid ? head.waddr : 5'd0;
    assign tr.tr_wdata = tr.tr_valid ? head.wdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= new_rec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            count   <= 8'd0;
            dropped <= 8'd0;
            level   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (eligible) count <= count + 8'd1;
            if (drop && (dropped != 8'hFF)) dropped <= dropped + 8'd1;

            case (state)
                S_IDLE, S_DONE: begin
                    // Re-arming restarts the window but leaves queued records to drain.
                    if (arm) begin
                        state   <= S_ARMED;
                        count   <= 8'd0;
                        dropped <= 8'd0;
                    end
                end
                S_ARMED: begin
                    if (hit) state <= last ? S_DONE : S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (last) state <= S_DONE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_trace_capture.sv
// Bench for cpu_trace_capture: vector table, directed windows, and random traffic vs a queue model.
module tb_cpu_trace_capture;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic [31:0] trig_addr = 32'h10;
    logic [31:0] pc = 32'h0;
    logic [5:0]  op = 6'h0;
    logic [4:0]  wa = 5'h0;
    logic [31:0] wd = 32'h0;
    logic        rw = 1'b0;
    logic [2:0]  rdy = 3'b000;

    logic [1:0] st0, st1, st2;
    logic [7:0] cnt0, cnt1, cnt2, drp0, drp1, drp2;
    logic [4:0] lv0, lv1;
    logic [2:0] lv2;

    always #5 clk = ~clk;

    cpu_trace_capture_if if0();
    cpu_trace_capture_if if1();
    cpu_trace_capture_if if2();
    assign if0.tr_ready = rdy[0];
    assign if1.tr_ready = rdy[1];
    assign if2.tr_ready = rdy[2];

    cpu_trace_capture #(.DEPTH(16), .CAPTURE_LEN(64), .FILTER_WB(0)) u0 (
        .clk(clk), .reset(reset), .arm(arm), .trig_addr(trig_addr), .currentAddress(pc),
        .op(op), .write_addr(wa), .WD(wd), .reg_write(rw), .tr(if0.master),
        .state(st0), .count(cnt0), .dropped(drp0), .level(lv0));
    cpu_trace_capture #(.DEPTH(16), .CAPTURE_LEN(64), .FILTER_WB(1)) u1 (
        .clk(clk), .reset(reset), .arm(arm), .trig_addr(trig_addr), .currentAddress(pc),
        .op(op), .write_addr(wa), .WD(wd), .reg_write(rw), .tr(if1.master),
        .state(st1), .count(cnt1), .dropped(drp1), .level(lv1));
    cpu_trace_capture #(.DEPTH(4), .CAPTURE_LEN(3), .FILTER_WB(1)) u2 (
        .clk(clk), .reset(reset), .arm(arm), .trig_addr(trig_addr), .currentAddress(pc),
        .op(op), .write_addr(wa), .WD(wd), .reg_write(rw), .tr(if2.master),
        .state(st2), .count(cnt2), .dropped(drp2), .level(lv2));

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  wa;
        logic [31:0] wd;
    } rec_t;

    // Reference model: one queue and a few counters per instance.
    int   MD [3] = '{16, 16, 4};
    int   ML [3] = '{64, 64, 3};
    int   MF [3] = '{0, 1, 1};
    rec_t mq [3][$];
    int   mst [3] = '{0, 0, 0};
    int   mcnt [3] = '{0, 0, 0};
    int   mdrp [3] = '{0, 0, 0};

    int n_cmp = 0;
    int n_bad = 0;
    int ncyc = 0;
    logic w0 = 1'b0;
    logic w1 = 1'b0;
    logic [31:0] exp0 = 32'h0;
    logic [31:0] exp1 = 32'h0;
    int np0 = 0;
    int np1 = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, ncyc, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            logic take;
            rec_t r;
            if (reset) begin
                mq[k].delete();
                mst[k] = 0; mcnt[k] = 0; mdrp[k] = 0;
            end else begin
                take = ((mst[k] == 2) || (mst[k] == 1 && pc == trig_addr)) && (MF[k] == 0 || rw);
                if (mq[k].size() > 0 && rdy[k]) void'(mq[k].pop_front());
                if (take) begin
                    mcnt[k]++;
                    r = '{pc, op, rw ? wa : 5'd0, rw ? wd : 32'd0};
                    if (mq[k].size() < MD[k]) mq[k].push_back(r);
                    else if (mdrp[k] < 255) mdrp[k]++;
                end
                if (mst[k] == 0 || mst[k] == 3) begin
                    if (arm) begin mst[k] = 1; mcnt[k] = 0; mdrp[k] = 0; end
                end else if (mst[k] == 1 && pc == trig_addr) begin
                    mst[k] = (mcnt[k] == ML[k]) ? 3 : 2;
                end else if (mst[k] == 2 && mcnt[k] == ML[k]) begin
                    mst[k] = 3;
                end
            end
        end
    endtask

    task automatic get_dut(input int k, output rec_t hd, output logic v, output int s, output int c,
                           output int d, output int l);
        case (k)
            0: begin hd = {if0.tr_pc, if0.tr_op, if0.tr_waddr, if0.tr_wdata}; v = if0.tr_valid;
                     s = st0; c = cnt0; d = drp0; l = lv0; end
            1: begin hd = {if1.tr_pc, if1.tr_op, if1.tr_waddr, if1.tr_wdata}; v = if1.tr_valid;
                     s = st1; c = cnt1; d = drp1; l = lv1; end
            default: begin hd = {if2.tr_pc, if2.tr_op, if2.tr_waddr, if2.tr_wdata}; v = if2.tr_valid;
                     s = st2; c = cnt2; d = drp2; l = lv2; end
        endcase
    endtask

    task automatic cmp_model();
        for (int k = 0; k < 3; k++) begin
            rec_t hd, eh;
            logic v;
            int s, c, d, l;
            get_dut(k, hd, v, s, c, d, l);
            eh = (mq[k].size() > 0) ? mq[k][0] : '0;
            chk($sformatf("u%0d state", k), s, mst[k]);
            chk($sformatf("u%0d count", k), c, mcnt[k]);
            chk($sformatf("u%0d dropped", k), d, mdrp[k]);
            chk($sformatf("u%0d level", k), l, mq[k].size());
            chk($sformatf("u%0d tr_valid", k), v, mq[k].size() > 0);
            chk($sformatf("u%0d head", k), hd, eh);
        end
    endtask

    task automatic cyc();
        if (w0 && if0.tr_valid && if0.tr_ready) begin
            chk("u0 pop pc", if0.tr_pc, exp0);
            exp0 += 4; np0++;
        end
        if (w1 && if1.tr_valid && if1.tr_ready) begin
            chk("u1 pop pc", if1.tr_pc, exp1);
            chk("u1 pop waddr", if1.tr_waddr, 5);
            chk("u1 pop wdata", if1.tr_wdata, 32'hDEADBEEF);
            exp1 += 8; np1++;
        end
        @(posedge clk);
        model_step();
        #1;
        cmp_model();
        ncyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; arm = 1'b0; cyc(); reset = 1'b0;
    endtask

    task automatic arm_at_zero();
        arm = 1'b1; pc = 32'h0; cyc(); arm = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic        arm;
        logic [31:0] pc;
        logic        rdy;
        logic [1:0]  est;
        logic [7:0]  ecnt;
        logic [4:0]  elvl;
        logic        ev;
        logic [31:0] epc;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 2'd0, 8'd0, 5'd0, 1'b0, 32'h00};
        vt[1] = '{1'b0, 1'b1, 32'h10, 1'b0, 2'd1, 8'd0, 5'd0, 1'b0, 32'h00};
        vt[2] = '{1'b0, 1'b0, 32'h00, 1'b0, 2'd1, 8'd0, 5'd0, 1'b0, 32'h00};
        vt[3] = '{1'b0, 1'b0, 32'h10, 1'b0, 2'd2, 8'd1, 5'd1, 1'b1, 32'h10};
        vt[4] = '{1'b0, 1'b0, 32'h14, 1'b0, 2'd2, 8'd2, 5'd2, 1'b1, 32'h10};
        vt[5] = '{1'b0, 1'b0, 32'h18, 1'b1, 2'd2, 8'd3, 5'd2, 1'b1, 32'h14};
        vt[6] = '{1'b0, 1'b1, 32'h1C, 1'b1, 2'd2, 8'd4, 5'd2, 1'b1, 32'h18};
        vt[7] = '{1'b1, 1'b0, 32'h20, 1'b1, 2'd0, 8'd0, 5'd0, 1'b0, 32'h00};

        for (int i = 0; i < 8; i++) begin
            reset = vt[i].rst; arm = vt[i].arm; pc = vt[i].pc; rdy = {3{vt[i].rdy}};
            cyc();
            chk($sformatf("vec%0d state", i), st0, vt[i].est);
            chk($sformatf("vec%0d count", i), cnt0, vt[i].ecnt);
            chk($sformatf("vec%0d level", i), lv0, vt[i].elvl);
            chk($sformatf("vec%0d tr_valid", i), if0.tr_valid, vt[i].ev);
            chk($sformatf("vec%0d tr_pc", i), if0.tr_pc, vt[i].epc);
        end
        reset = 1'b0; arm = 1'b0;

        // Full window with a ready consumer.
        rw = 1'b0; rdy = 3'b111; do_reset(); arm_at_zero();
        w0 = 1'b1; exp0 = 32'h10; np0 = 0;
        for (int i = 1; i <= 3; i++) begin pc = i * 4; cyc(); end
        chk("t1 armed before trigger", st0, 1);
        pc = 32'h10; cyc();
        chk("t1 capture at trigger", st0, 2);
        for (int i = 0; i < 200 && st0 != 2'd3; i++) begin pc += 4; cyc(); end
        chk("t1 done state", st0, 3);
        chk("t1 done count", cnt0, 64);
        chk("t1 done dropped", drp0, 0);
        chk("t1 last pc", pc, 32'h10C);
        pc = 32'h1000; repeat (4) cyc();
        chk("t1 pops", np0, 64);
        w0 = 1'b0;

        // Writeback-only window.
        do_reset(); wa = 5'd5; wd = 32'hDEADBEEF; arm_at_zero();
        w1 = 1'b1; exp1 = 32'h14; np1 = 0;
        for (int i = 0; i < 400 && st1 != 2'd3; i++) begin pc += 4; rw = pc[2]; cyc(); end
        chk("t3 done state", st1, 3);
        chk("t3 last pc", pc, 32'h20C);
        rw = 1'b0; pc = 32'h1000; repeat (4) cyc();
        chk("t3 pops", np1, 64);
        w1 = 1'b0;

        // Stalled consumer, drain, then re-arm with records still queued.
        rdy = 3'b000; do_reset(); arm_at_zero();
        for (int i = 0; i < 200 && st0 != 2'd3; i++) begin pc += 4; cyc(); end
        chk("t2 state", st0, 3);
        chk("t2 level", lv0, 16);
        chk("t2 dropped", drp0, 48);
        chk("t2 count", cnt0, 64);
        pc = 32'h1000; w0 = 1'b1; exp0 = 32'h10; np0 = 0; rdy = 3'b111;
        for (int i = 0; i < 50 && lv0 != 5'd3; i++) cyc();
        chk("t6 level before arm", lv0, 3);
        rdy = 3'b000; arm = 1'b1; cyc(); arm = 1'b0;
        chk("t6 rearm state", st0, 1);
        chk("t6 rearm count", cnt0, 0);
        chk("t6 rearm dropped", drp0, 0);
        chk("t6 rearm level", lv0, 3);
        rdy = 3'b111;
        for (int i = 0; i < 50 && lv0 != 5'd0; i++) cyc();
        chk("t2 drained records", np0, 16);
        chk("t2 next expected pc", exp0, 32'h50);
        w0 = 1'b0;

        // Full FIFO with a pop and a push in the same cycle.
        rdy = 3'b000; do_reset(); arm_at_zero();
        for (int i = 0; i < 100 && drp0 != 8'd2; i++) begin pc += 4; cyc(); end
        chk("t4 level full", lv0, 16);
        pc += 4; rdy = 3'b111; cyc();
        chk("t4 level kept", lv0, 16);
        chk("t4 dropped kept", drp0, 2);
        chk("t4 new head", if0.tr_pc, 32'h14);
        rdy = 3'b000;

        // Reset in the middle of a capture.
        do_reset(); arm_at_zero();
        for (int i = 0; i < 100 && lv0 != 5'd7; i++) begin pc += 4; cyc(); end
        chk("t5 level before reset", lv0, 7);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("t5 state", st0, 0);
        chk("t5 tr_valid", if0.tr_valid, 0);
        chk("t5 level", lv0, 0);
        chk("t5 count", cnt0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = (i / 200) % 4;
            reset = ($urandom_range(0, 299) == 0);
            arm = ($urandom_range(0, 9) == 0);
            pc = 32'h10 + 4 * $urandom_range(0, 4);
            op = 6'($urandom);
            wa = 5'($urandom);
            wd = $urandom;
            rw = $urandom_range(0, 1);
            for (int k = 0; k < 3; k++) rdy[k] = ($urandom_range(0, 3) < bias + 1);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
